// File: rtl/imem_boot_loader_if.sv
// Host word stream into the boot loader: valid/ready handshake carrying one
// instruction word per transfer (transfer = s_valid & s_ready).
interface imem_boot_loader_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: streams host words into instruction memory from word 0,
// accumulates an additive checksum, and releases the core reset only when the
// checksum matches. Failures (bad length, stall timeout, bad sum) park in ERROR.
module imem_boot_loader #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     load_len,
  input  logic [DATA_W-1:0]   exp_sum,
  imem_boot_loader_if.slave   s,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [DATA_W-1:0]   mem_wd,
  output logic                cpu_rst_n,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [ADDR_W:0] DEPTH_L  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic idle_like;
  logic len_ok;
  logic xfer;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign len_ok    = (load_len != '0) && (load_len <= DEPTH_L);
  assign xfer      = (state_q == ST_LOAD) && s.s_valid;
  assign s.s_ready = (state_q == ST_LOAD);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: start only in idle-like states; LOAD leaves on last word or stall timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_d = len_ok ? ST_LOAD : ST_ERROR;
      end
      ST_LOAD: begin
        if (xfer) begin
          if (idx_q == len_q - 1'b1) state_d = ST_CHECK;
        end else if (timer_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end
      end
      ST_CHECK: state_d = (sum_q == exp_q) ? ST_DONE : ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; status flags follow the state being entered
  always_comb begin
    len_d      = len_q;
    exp_d      = exp_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    timer_d    = timer_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;

    if (idle_like && start && len_ok) begin
      len_d   = load_len;
      exp_d   = exp_sum;
      idx_d   = '0;
      sum_d   = '0;
      timer_d = '0;
    end

    if (state_q == ST_LOAD) begin
      if (xfer) begin
        mem_we_d   = 1'b1;
        mem_addr_d = {{(30-ADDR_W){1'b0}}, idx_q[ADDR_W-1:0], 2'b00};
        mem_wd_d   = s.s_data;
        sum_d      = sum_q + s.s_data;
        idx_d      = idx_q + 1'b1;
        timer_d    = '0;
      end else begin
        timer_d    = timer_q + 1'b1;
      end
    end

    busy_d      = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERROR);
    cpu_rst_n_d = (state_d == ST_DONE);
  end

  // Datapath/output registers; reset kills an in-flight write immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q       <= '0;
      exp_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      timer_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wd_q    <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      len_q       <= len_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      timer_q     <= timer_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wd    = mem_wd_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
